spi_reg_ctrl: RTL

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl_pkg.sv | 22 ++
 rtl/sync_edge.sv | 37 +++
 rtl/spi_reg_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared definitions for the SPI register controller: FSM states,
// register map addresses and frame geometry.
package spi_reg_ctrl_pkg;

    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;

    localparam logic [CNT_W-1:0] FRAME_CNT = 5'd16;

    localparam logic [6:0] ADDR_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY = 7'h04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, followed by rise/fall
// detection on the synchronized level.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, which is what makes the chain shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 write-only register controller: captures 16-bit frames and
// commits valid writes into five 8-bit configuration registers.
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_commit
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .dout(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .dout(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    // Edge outputs this block has no use for are collected here.
    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 commit_en;

    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_ok;

    assign frame_addr = shift_q[14:8];
    assign frame_data = shift_q[7:0];
    assign frame_ok   = (cnt_q == FRAME_CNT) && shift_q[FRAME_W-1]
                     && (frame_addr <= MAX_ADDR) && (frame_addr <= ADDR_PWM_DUTY);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        commit_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // ncs rising wins over a simultaneous sclk edge.
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise && !ncs_lvl && (cnt_q < FRAME_CNT)) begin
                    shift_d = {shift_q[FRAME_W-2:0], copi_lvl};
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            ST_COMMIT: begin
                state_d   = ST_IDLE;
                commit_en = frame_ok;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            wr_commit       <= 1'b0;
        end else begin
            wr_commit <= commit_en;
            if (commit_en) begin
                case (frame_addr)
                    ADDR_OUT_7_0:  en_reg_out_7_0  <= frame_data;
                    ADDR_OUT_15_8: en_reg_out_15_8 <= frame_data;
                    ADDR_PWM_7_0:  en_reg_pwm_7_0  <= frame_data;
                    ADDR_PWM_15_8: en_reg_pwm_15_8 <= frame_data;
                    ADDR_PWM_DUTY: pwm_duty_cycle  <= frame_data;
                    default: ;
                endcase
            end
        end
    end

endmodule
